gate_sequencer: RTL and testbench

- Measurement controller for the Counter2 frequency-counter path.
- Contains an internal programmable timebase divider that produces one-cycle ticks.
- Sequences gate windows of an exact number of ticks and counts rising edges of an external event input during each window.
- Hands each window's count to downstream logic over a valid/ready handshake; runs single-shot or continuous.

---
 rtl/gate_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_gate_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sequencer.sv
// Frequency-counter gate sequencer: programmable timebase, exact-length gate windows,
// synchronized event edge counting and valid/ready result hand-off.
module gate_sequencer #(
    parameter int unsigned DIV_BITS  = 16,
    parameter int unsigned GATE_BITS = 16,
    parameter int unsigned CNT_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_BITS-1:0]  cfg_div,
    input  logic [GATE_BITS-1:0] cfg_gate,
    input  logic                 cfg_cont,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 evt_in,
    output logic                 busy,
    output logic                 tick,
    output logic                 gate,
    output logic [CNT_BITS-1:0]  result,
    output logic                 result_sat,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2
    } state_e;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [DIV_BITS-1:0]  div_q, div_d;
    logic [GATE_BITS-1:0] gate_len_q, gate_len_d;
    logic                 cont_q, cont_d;
    logic [DIV_BITS-1:0]  presc_q, presc_d;
    logic [GATE_BITS-1:0] tick_cnt_q, tick_cnt_d;
    logic [CNT_BITS-1:0]  evt_cnt_q, evt_cnt_d;
    logic                 sat_q, sat_d;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic                 tick_q, tick_d;
    logic                 gate_q, gate_d;
    logic                 busy_q, busy_d;
    logic [CNT_BITS-1:0]  result_q, result_d;
    logic                 result_sat_q, result_sat_d;
    logic                 result_valid_q, result_valid_d;
    logic                 overrun_q, overrun_d;

    logic                 edge_c;
    logic                 closing_c;
    logic                 at_max_c;
    logic [DIV_BITS-1:0]  presc_wrap_c;
    logic [CNT_BITS-1:0]  cnt_next_c;
    logic                 sat_next_c;

    // Next-state, counters and registered outputs
    always_comb begin
        state_d        = state_q;
        div_d          = div_q;
        gate_len_d     = gate_len_q;
        cont_d         = cont_q;
        presc_d        = presc_q;
        tick_cnt_d     = tick_cnt_q;
        evt_cnt_d      = evt_cnt_q;
        sat_d          = sat_q;
        result_d       = result_q;
        result_sat_d   = result_sat_q;
        result_valid_d = result_valid_q;
        overrun_d      = overrun_q;

        sync1_d = evt_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;

        edge_c       = sync2_q & ~sync3_q;
        presc_wrap_c = (presc_q == div_q - DIV_BITS'(1)) ? '0 : presc_q + DIV_BITS'(1);
        closing_c    = (state_q == S_GATE) && tick_q && (tick_cnt_q == gate_len_q - GATE_BITS'(1));
        at_max_c     = (evt_cnt_q == CNT_MAX);
        cnt_next_c   = (edge_c && !at_max_c) ? evt_cnt_q + CNT_BITS'(1) : evt_cnt_q;
        sat_next_c   = sat_q | (edge_c & at_max_c);

        if (result_ready) begin
            result_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                if (start && !stop) begin
                    state_d    = S_ARM;
                    div_d      = (cfg_div == '0) ? DIV_BITS'(1) : cfg_div;
                    gate_len_d = (cfg_gate == '0) ? GATE_BITS'(1) : cfg_gate;
                    cont_d     = cfg_cont;
                    overrun_d  = 1'b0;
                end
            end
            S_ARM: begin
                presc_d    = presc_wrap_c;
                tick_cnt_d = '0;
                evt_cnt_d  = '0;
                sat_d      = 1'b0;
                if (stop) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                end else if (tick_q) begin
                    state_d = S_GATE;
                end
            end
            S_GATE: begin
                presc_d   = presc_wrap_c;
                evt_cnt_d = cnt_next_c;
                sat_d     = sat_next_c;
                if (tick_q) begin
                    tick_cnt_d = tick_cnt_q + GATE_BITS'(1);
                end
                if (stop) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                end else if (closing_c) begin
                    // A result still waiting for the consumer is kept; the new one is dropped
                    if (!result_valid_q || result_ready) begin
                        result_d       = cnt_next_c;
                        result_sat_d   = sat_next_c;
                        result_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    tick_cnt_d = '0;
                    evt_cnt_d  = '0;
                    sat_d      = 1'b0;
                    if (!cont_q) begin
                        state_d = S_IDLE;
                        presc_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                presc_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        gate_d = (state_d == S_GATE);
        tick_d = busy_d && (presc_d == div_d - DIV_BITS'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            div_q          <= '0;
            gate_len_q     <= '0;
            cont_q         <= 1'b0;
            presc_q        <= '0;
            tick_cnt_q     <= '0;
            evt_cnt_q      <= '0;
            sat_q          <= 1'b0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            tick_q         <= 1'b0;
            gate_q         <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_sat_q   <= 1'b0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            gate_len_q     <= gate_len_d;
            cont_q         <= cont_d;
            presc_q        <= presc_d;
            tick_cnt_q     <= tick_cnt_d;
            evt_cnt_q      <= evt_cnt_d;
            sat_q          <= sat_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            tick_q         <= tick_d;
            gate_q         <= gate_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_sat_q   <= result_sat_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign busy         = busy_q;
    assign tick         = tick_q;
    assign gate         = gate_q;
    assign result       = result_q;
    assign result_sat   = result_sat_q;
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: timing of tick/gate, window results, back-pressure,
// saturation (narrow counter instance), stop and asynchronous reset.
module tb_gate_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] cfg_div;
    logic [15:0] cfg_gate;
    logic        cfg_cont;
    logic        start;
    logic        stop;
    logic        evt_in;
    logic        busy;
    logic        tick;
    logic        gate;
    logic [31:0] result;
    logic        result_sat;
    logic        result_valid;
    logic        result_ready;
    logic        overrun;

    logic        start_s;
    logic        evt_s;
    logic        busy_s;
    logic        tick_s;
    logic        gate_s;
    logic [3:0]  result_s;
    logic        result_sat_s;
    logic        result_valid_s;
    logic        overrun_s;

    int n_pass;
    int n_total;

    gate_sequencer u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_div      (cfg_div),
        .cfg_gate     (cfg_gate),
        .cfg_cont     (cfg_cont),
        .start        (start),
        .stop         (stop),
        .evt_in       (evt_in),
        .busy         (busy),
        .tick         (tick),
        .gate         (gate),
        .result       (result),
        .result_sat   (result_sat),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    gate_sequencer #(.DIV_BITS(16), .GATE_BITS(16), .CNT_BITS(4)) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_div      (cfg_div),
        .cfg_gate     (cfg_gate),
        .cfg_cont     (cfg_cont),
        .start        (start_s),
        .stop         (stop),
        .evt_in       (evt_s),
        .busy         (busy_s),
        .tick         (tick_s),
        .gate         (gate_s),
        .result       (result_s),
        .result_sat   (result_sat_s),
        .result_valid (result_valid_s),
        .result_ready (result_ready),
        .overrun      (overrun_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle c of a test begins 1 time unit after its rising edge
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_total++; if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else n_pass++;
        n_total++; if (tick !== 1'b0) $display("FAIL reset tick got %b exp 0", tick); else n_pass++;
        n_total++; if (gate !== 1'b0) $display("FAIL reset gate got %b exp 0", gate); else n_pass++;
        n_total++; if (result !== 32'd0) $display("FAIL reset result got %0d exp 0", result); else n_pass++;
        n_total++; if (result_valid !== 1'b0) $display("FAIL reset valid got %b exp 0", result_valid); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL reset overrun got %b exp 0", overrun); else n_pass++;
        #10;
        rst_n = 1'b1;
    endtask

    // div=4, gate=3: ticks at 4,8,12,16; gate 5..16; evt rises at 4 and 14 -> pulses 6 and 16
    task automatic test_single_shot(input string tag);
        logic exp_tick, exp_gate, exp_busy;
        cfg_div = 16'd4; cfg_gate = 16'd3; cfg_cont = 1'b0;
        result_ready = 1'b0; stop = 1'b0; evt_in = 1'b0;
        repeat (4) next_cyc();
        start = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            next_cyc();
            start = 1'b0;
            exp_tick = (c % 4 == 0) && (c <= 16);
            exp_gate = (c >= 5) && (c <= 16);
            exp_busy = (c <= 16);
            n_total++; if (tick !== exp_tick) $display("FAIL %s tick c=%0d got %b exp %b", tag, c, tick, exp_tick); else n_pass++;
            n_total++; if (gate !== exp_gate) $display("FAIL %s gate c=%0d got %b exp %b", tag, c, gate, exp_gate); else n_pass++;
            n_total++; if (busy !== exp_busy) $display("FAIL %s busy c=%0d got %b exp %b", tag, c, busy, exp_busy); else n_pass++;
            evt_in = (((c + 6) % 10) < 5);
        end
        n_total++; if (result_valid !== 1'b1) $display("FAIL %s valid got %b exp 1", tag, result_valid); else n_pass++;
        n_total++; if (result !== 32'd2) $display("FAIL %s result got %0d exp 2", tag, result); else n_pass++;
        n_total++; if (result_sat !== 1'b0) $display("FAIL %s sat got %b exp 0", tag, result_sat); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL %s overrun got %b exp 0", tag, overrun); else n_pass++;
        result_ready = 1'b1;
        next_cyc();
        n_total++; if (result_valid !== 1'b0) $display("FAIL %s valid_drop got %b exp 0", tag, result_valid); else n_pass++;
        result_ready = 1'b0;
        evt_in = 1'b0;
    endtask

    task automatic test_degenerate();
        logic exp_tick, exp_gate, exp_busy;
        cfg_div = 16'd0; cfg_gate = 16'd0; cfg_cont = 1'b0;
        evt_in = 1'b1;
        repeat (5) next_cyc();
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            next_cyc();
            start = 1'b0;
            exp_tick = (c <= 2);
            exp_gate = (c == 2);
            exp_busy = (c <= 2);
            n_total++; if (tick !== exp_tick) $display("FAIL degen tick c=%0d got %b exp %b", c, tick, exp_tick); else n_pass++;
            n_total++; if (gate !== exp_gate) $display("FAIL degen gate c=%0d got %b exp %b", c, gate, exp_gate); else n_pass++;
            n_total++; if (busy !== exp_busy) $display("FAIL degen busy c=%0d got %b exp %b", c, busy, exp_busy); else n_pass++;
        end
        n_total++; if (result_valid !== 1'b1) $display("FAIL degen valid got %b exp 1", result_valid); else n_pass++;
        n_total++; if (result !== 32'd0) $display("FAIL degen result got %0d exp 0", result); else n_pass++;
        result_ready = 1'b1;
        next_cyc();
        result_ready = 1'b0;
        evt_in = 1'b0;
    endtask

    // div=2, gate=5, continuous: windows 3..12, 13..22, 23..32, 33..42 with 1,2,2,1 edges
    task automatic test_continuous();
        cfg_div = 16'd2; cfg_gate = 16'd5; cfg_cont = 1'b1;
        result_ready = 1'b0; evt_in = 1'b0;
        repeat (4) next_cyc();
        start = 1'b1;
        evt_in = 1'b1;
        for (int c = 1; c <= 43; c++) begin
            next_cyc();
            start = 1'b0;
            n_total++; if (gate !== (c >= 3)) $display("FAIL cont gate c=%0d got %b exp %b", c, gate, (c >= 3)); else n_pass++;
            if (c >= 13 && c <= 23) begin
                n_total++; if (result_valid !== 1'b1) $display("FAIL cont hold_valid c=%0d got %b exp 1", c, result_valid); else n_pass++;
                n_total++; if (result !== 32'd1) $display("FAIL cont hold_result c=%0d got %0d exp 1", c, result); else n_pass++;
            end
            if (c == 22) begin
                n_total++; if (overrun !== 1'b0) $display("FAIL cont overrun_pre got %b exp 0", overrun); else n_pass++;
            end
            if (c == 23) begin
                n_total++; if (overrun !== 1'b1) $display("FAIL cont overrun got %b exp 1", overrun); else n_pass++;
                result_ready = 1'b1;
            end
            if (c == 24 || c == 34) begin
                n_total++; if (result_valid !== 1'b0) $display("FAIL cont valid_drop c=%0d got %b exp 0", c, result_valid); else n_pass++;
            end
            if (c == 33) begin
                n_total++; if (result_valid !== 1'b1) $display("FAIL cont w3_valid got %b exp 1", result_valid); else n_pass++;
                n_total++; if (result !== 32'd2) $display("FAIL cont w3_result got %0d exp 2", result); else n_pass++;
            end
            if (c == 43) begin
                n_total++; if (result_valid !== 1'b1) $display("FAIL cont w4_valid got %b exp 1", result_valid); else n_pass++;
                n_total++; if (result !== 32'd1) $display("FAIL cont w4_result got %0d exp 1", result); else n_pass++;
                n_total++; if (overrun !== 1'b1) $display("FAIL cont overrun_sticky got %b exp 1", overrun); else n_pass++;
            end
            evt_in = ((c % 6) < 3);
        end
        stop = 1'b1;
        next_cyc();
        stop = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL cont stop_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (gate !== 1'b0) $display("FAIL cont stop_gate got %b exp 0", gate); else n_pass++;
        result_ready = 1'b0;
        evt_in = 1'b0;
    endtask

    task automatic test_stop();
        logic exp_gate, exp_busy;
        cfg_div = 16'd4; cfg_gate = 16'd3; cfg_cont = 1'b0;
        result_ready = 1'b0; evt_in = 1'b0;
        repeat (4) next_cyc();
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            next_cyc();
            start = 1'b0;
            stop = 1'b0;
            exp_gate = (c >= 5) && (c <= 9);
            exp_busy = (c <= 9);
            if (c == 1) begin
                n_total++; if (overrun !== 1'b0) $display("FAIL stop overrun_clr got %b exp 0", overrun); else n_pass++;
            end
            n_total++; if (gate !== exp_gate) $display("FAIL stop gate c=%0d got %b exp %b", c, gate, exp_gate); else n_pass++;
            n_total++; if (busy !== exp_busy) $display("FAIL stop busy c=%0d got %b exp %b", c, busy, exp_busy); else n_pass++;
            n_total++; if (result_valid !== 1'b0) $display("FAIL stop valid c=%0d got %b exp 0", c, result_valid); else n_pass++;
            if (c == 9) stop = 1'b1;
            evt_in = (c % 3 == 0);
        end
        evt_in = 1'b0;
        start = 1'b1;
        stop = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cyc();
            start = 1'b0;
            stop = 1'b0;
            n_total++; if (busy !== 1'b0) $display("FAIL stop start_stop_busy c=%0d got %b exp 0", c, busy); else n_pass++;
        end
    endtask

    // div=4, gate=25 on the 4-bit counter: 25 edges in a 100-cycle window
    task automatic test_saturation();
        cfg_div = 16'd4; cfg_gate = 16'd25; cfg_cont = 1'b0;
        result_ready = 1'b0; evt_s = 1'b0;
        repeat (4) next_cyc();
        start_s = 1'b1;
        evt_s = 1'b1;
        for (int c = 1; c <= 105; c++) begin
            next_cyc();
            start_s = 1'b0;
            if (c == 4) begin
                n_total++; if (tick_s !== 1'b1) $display("FAIL sat first_tick got %b exp 1", tick_s); else n_pass++;
            end
            if (c == 104) begin
                n_total++; if (gate_s !== 1'b1) $display("FAIL sat gate_last got %b exp 1", gate_s); else n_pass++;
            end
            evt_s = ((c % 4) < 2);
        end
        n_total++; if (gate_s !== 1'b0) $display("FAIL sat gate_end got %b exp 0", gate_s); else n_pass++;
        n_total++; if (result_valid_s !== 1'b1) $display("FAIL sat valid got %b exp 1", result_valid_s); else n_pass++;
        n_total++; if (result_s !== 4'd15) $display("FAIL sat result got %0d exp 15", result_s); else n_pass++;
        n_total++; if (result_sat_s !== 1'b1) $display("FAIL sat flag got %b exp 1", result_sat_s); else n_pass++;
        n_total++; if (busy_s !== 1'b0) $display("FAIL sat busy got %b exp 0", busy_s); else n_pass++;
        n_total++; if (overrun_s !== 1'b0) $display("FAIL sat overrun got %b exp 0", overrun_s); else n_pass++;
        evt_s = 1'b0;
    endtask

    task automatic test_reset_mid_window();
        cfg_div = 16'd2; cfg_gate = 16'd5; cfg_cont = 1'b1;
        result_ready = 1'b0; evt_in = 1'b0;
        repeat (4) next_cyc();
        start = 1'b1;
        evt_in = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            next_cyc();
            start = 1'b0;
            evt_in = ((c % 6) < 3);
        end
        n_total++; if (result_valid !== 1'b1) $display("FAIL rstmid pre_valid got %b exp 1", result_valid); else n_pass++;
        n_total++; if (gate !== 1'b1) $display("FAIL rstmid pre_gate got %b exp 1", gate); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid busy got %b exp 0", busy); else n_pass++;
        n_total++; if (tick !== 1'b0) $display("FAIL rstmid tick got %b exp 0", tick); else n_pass++;
        n_total++; if (gate !== 1'b0) $display("FAIL rstmid gate got %b exp 0", gate); else n_pass++;
        n_total++; if (result !== 32'd0) $display("FAIL rstmid result got %0d exp 0", result); else n_pass++;
        n_total++; if (result_sat !== 1'b0) $display("FAIL rstmid sat got %b exp 0", result_sat); else n_pass++;
        n_total++; if (result_valid !== 1'b0) $display("FAIL rstmid valid got %b exp 0", result_valid); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL rstmid overrun got %b exp 0", overrun); else n_pass++;
        evt_in = 1'b0;
        #8;
        rst_n = 1'b1;
        test_single_shot("post_reset");
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        cfg_div = 16'd0; cfg_gate = 16'd0; cfg_cont = 1'b0;
        start = 1'b0; stop = 1'b0; evt_in = 1'b0;
        start_s = 1'b0; evt_s = 1'b0;
        result_ready = 1'b0;
        test_reset();
        test_single_shot("single");
        test_degenerate();
        test_continuous();
        test_stop();
        test_saturation();
        test_reset_mid_window();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
